lock_led_driver: RTL and testbench

LOCK_LED_DRIVER -- requirements
Module: lock_led_driver

---
 rtl/lock_pkg.sv | 35 +++
 rtl/cycle_timer.sv | 28 ++
 rtl/lock_led_driver.sv | 206 ++++++++++++++++++++
 tb/tb_lock_led_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock subsystem: FSM state encodings used by
// the LED driver, plus the code format used by the keypad lock FSM.
package lock_pkg;

    // LED driver FSM state encodings (also exported on the debug state port)
    localparam logic [1:0] ST_LOCKED     = 2'd0;
    localparam logic [1:0] ST_UNLOCKED   = 2'd1;
    localparam logic [1:0] ST_FAIL_FLASH = 2'd2;
    localparam logic [1:0] ST_LOCKOUT    = 2'd3;

    // Keypad code format shared with the lock FSM
    localparam int CODE_DIGITS = 4;
    localparam int DIGIT_W     = 4;

    typedef logic [DIGIT_W-1:0]             digit_t;
    typedef logic [CODE_DIGITS*DIGIT_W-1:0] code_t;

    // Result of one code-entry attempt as reported by the lock FSM
    typedef struct packed {
        logic unlock;
        logic fail;
        logic relock;
    } lock_event_t;

    // Larger of two integers, used for sizing counters at elaboration time
    function automatic int lock_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Compare an entered code against the stored code
    function automatic logic code_match(input code_t entered, input code_t stored);
        return (entered == stored);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter. Loading N gives N further cycles with done low,
// then done rises and the counter holds at zero until the next load.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_reg;

    // Count down towards zero and stop there; a load always wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign done = (count_reg == '0);

endmodule

// File: rtl/lock_led_driver.sv
// Lock status LED driver: dims red while locked, dims green while unlocked,
// blinks red after a wrong code and, when LOCK_LED_LOCKOUT_EN is defined,
// holds a red lockout after MAX_FAILS consecutive wrong codes.
// Build option: define LOCK_LED_LOCKOUT_EN to include the fail counter and
// the LOCKOUT state; without it a failure flash always returns to LOCKED.
module lock_led_driver
    import lock_pkg::*;
#(
    parameter int BLINK_HALF     = 25_000_000,
    parameter int FLASH_BLINKS   = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_12p5,
    input  logic       pwm_25,
    input  logic       unlock_pulse,
    input  logic       fail_pulse,
    input  logic       lock_pulse,
    output logic       led_r,
    output logic       led_g,
    output logic       busy,
    output logic [1:0] state
);

    // One timer serves both the blink half-period and the lockout period
    localparam int TW = $clog2(lock_max(BLINK_HALF, LOCKOUT_CYCLES) + 1);
    localparam logic [TW-1:0] BLINK_LOAD = TW'(BLINK_HALF - 1);

    // Half-period counter for the flash sequence
    localparam int HALVES = 2 * FLASH_BLINKS;
    localparam int HW     = $clog2(HALVES);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALVES - 1);

    // Reject configurations that would make the timers meaningless
    if (BLINK_HALF < 1 || FLASH_BLINKS < 1 || MAX_FAILS < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
        $error("lock_led_driver: all timing and count parameters must be >= 1");
    end

`ifdef LOCK_LED_LOCKOUT_EN
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

    logic [FW-1:0] fail_cnt_reg;
    logic [FW-1:0] fail_cnt_next;
`endif

    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic          phase_reg;
    logic          phase_next;
    logic [HW-1:0] half_reg;
    logic [HW-1:0] half_next;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          led_r_reg;
    logic          led_r_next;
    logic          led_g_reg;
    logic          led_g_next;

    cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state logic: pulses are only honoured in LOCKED and UNLOCKED
    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        half_next  = half_reg;
        tmr_load   = 1'b0;
        tmr_val    = BLINK_LOAD;
`ifdef LOCK_LED_LOCKOUT_EN
        fail_cnt_next = fail_cnt_reg;
`endif
        case (state_reg)
            ST_LOCKED: begin
                // A wrong code outranks a simultaneous correct one
                if (fail_pulse) begin
                    state_next = ST_FAIL_FLASH;
                    phase_next = 1'b1;
                    half_next  = '0;
                    tmr_load   = 1'b1;
                    tmr_val    = BLINK_LOAD;
`ifdef LOCK_LED_LOCKOUT_EN
                    if (fail_cnt_reg != FAIL_MAX) begin
                        fail_cnt_next = fail_cnt_reg + FW'(1);
                    end
`endif
                end else if (unlock_pulse) begin
                    state_next = ST_UNLOCKED;
`ifdef LOCK_LED_LOCKOUT_EN
                    fail_cnt_next = '0;
`endif
                end
            end
            ST_UNLOCKED: begin
                if (lock_pulse) begin
                    state_next = ST_LOCKED;
                end
            end
            ST_FAIL_FLASH: begin
                if (tmr_done) begin
                    if (half_reg == HALF_LAST) begin
                        phase_next = 1'b1;
                        half_next  = '0;
`ifdef LOCK_LED_LOCKOUT_EN
                        if (fail_cnt_reg == FAIL_MAX) begin
                            state_next = ST_LOCKOUT;
                            tmr_load   = 1'b1;
                            tmr_val    = LOCKOUT_LOAD;
                        end else begin
                            state_next = ST_LOCKED;
                        end
`else
                        state_next = ST_LOCKED;
`endif
                    end else begin
                        half_next  = half_reg + HW'(1);
                        phase_next = ~phase_reg;
                        tmr_load   = 1'b1;
                        tmr_val    = BLINK_LOAD;
                    end
                end
            end
`ifdef LOCK_LED_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (tmr_done) begin
                    state_next    = ST_LOCKED;
                    fail_cnt_next = '0;
                end
            end
`endif
            default: begin
                state_next = ST_LOCKED;
            end
        endcase
    end

    // FSM state, blink phase and half-period count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_LOCKED;
            phase_reg <= 1'b1;
            half_reg  <= '0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            half_reg  <= half_next;
        end
    end

`ifdef LOCK_LED_LOCKOUT_EN
    // Consecutive-failure counter, cleared by a good code or a served lockout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_cnt_reg <= '0;
        end else begin
            fail_cnt_reg <= fail_cnt_next;
        end
    end
`endif

    // LED pattern selected by the current state
    always_comb begin
        led_r_next = 1'b0;
        led_g_next = 1'b0;
        case (state_reg)
            ST_LOCKED:     led_r_next = pwm_12p5;
            ST_UNLOCKED:   led_g_next = pwm_25;
            ST_FAIL_FLASH: led_r_next = pwm_25 & phase_reg;
`ifdef LOCK_LED_LOCKOUT_EN
            ST_LOCKOUT:    led_r_next = pwm_25;
`endif
            default: begin
                led_r_next = 1'b0;
                led_g_next = 1'b0;
            end
        endcase
    end

    // Registered LED drives, one cycle behind the PWM inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r_reg <= 1'b0;
            led_g_reg <= 1'b0;
        end else begin
            led_r_reg <= led_r_next;
            led_g_reg <= led_g_next;
        end
    end

    assign led_r = led_r_reg;
    assign led_g = led_g_reg;
    assign state = state_reg;
    assign busy  = (state_reg == ST_FAIL_FLASH) || (state_reg == ST_LOCKOUT);

endmodule

// File: tb/tb_lock_led_driver.sv
// Bench for lock_led_driver with BLINK_HALF=4, FLASH_BLINKS=2, MAX_FAILS=3,
// LOCKOUT_CYCLES=20. Stimulus pushes the expected observation for each cycle;
// a monitor pops and compares on the falling edge.
module tb_lock_led_driver;

`ifdef LOCK_LED_LOCKOUT_EN
    localparam bit LOCKOUT_ON = 1'b1;
`else
    localparam bit LOCKOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pwm_12p5 = 1'b0;
    logic       pwm_25 = 1'b0;
    logic       unlock_pulse = 1'b0;
    logic       fail_pulse = 1'b0;
    logic       lock_pulse = 1'b0;
    logic       led_r;
    logic       led_g;
    logic       busy;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] st;
        logic       r;
        logic       g;
        logic       b;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    lock_led_driver #(
        .BLINK_HALF     (4),
        .FLASH_BLINKS   (2),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pwm_12p5     (pwm_12p5),
        .pwm_25       (pwm_25),
        .unlock_pulse (unlock_pulse),
        .fail_pulse   (fail_pulse),
        .lock_pulse   (lock_pulse),
        .led_r        (led_r),
        .led_g        (led_g),
        .busy         (busy),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Monitor: compare the DUT against each expected observation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({state, led_r, led_g, busy} !== {e.st, e.r, e.g, e.b}) begin
                bad++;
                $display("FAIL %s: got state=%0d r=%b g=%b busy=%b, want state=%0d r=%b g=%b busy=%b",
                         e.tag, state, led_r, led_g, busy, e.st, e.r, e.g, e.b);
            end else begin
                $display("ok   %s: state=%0d r=%b g=%b busy=%b", e.tag, state, led_r, led_g, busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [1:0] st, input logic r, input logic g, input logic b,
                            input string tag);
        exp_t e;
        e.st = st; e.r = r; e.g = g; e.b = b; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs just after the rising edge, expect this cycle's outputs
    task automatic cyc(input logic p12, input logic p25, input logic un, input logic fl,
                       input logic lk, input logic [1:0] es, input logic er, input logic eg,
                       input logic eb, input string tag);
        pwm_12p5 = p12; pwm_25 = p25;
        unlock_pulse = un; fail_pulse = fl; lock_pulse = lk;
        push_exp(es, er, eg, eb, tag);
        @(posedge clk); #1;
    endtask

    // Unlock from LOCKED, ignored pulses while UNLOCKED, then relock
    task automatic unlock_relock(input string tag);
        cyc(0, 1, 1, 0, 0, 2'd0, 0, 0, 0, {tag, "_unl_acc"});
        cyc(0, 1, 0, 0, 0, 2'd1, 0, 0, 0, {tag, "_unl_st"});
        cyc(0, 0, 0, 1, 0, 2'd1, 0, 1, 0, {tag, "_unl_g1"});
        cyc(0, 1, 1, 0, 0, 2'd1, 0, 0, 0, {tag, "_unl_g0"});
        cyc(0, 1, 0, 0, 1, 2'd1, 0, 1, 0, {tag, "_unl_g1b"});
        cyc(0, 0, 0, 0, 0, 2'd0, 0, 1, 0, {tag, "_relock"});
        cyc(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, {tag, "_relock_led"});
    endtask

    // Failure flash with pwm_25 high: 4 on / 4 off twice, LEDs one cycle late.
    // Optionally followed by lockout; stop_at>0 ends after that many lockout cycles.
    task automatic flash(input logic co_un, input bit exp_lock, input int stop_at,
                         input string tag);
        int n;
        logic on;
        cyc(0, 1, co_un, 1, 0, 2'd0, 0, 0, 0, {tag, "_acc"});
        for (int j = 1; j <= 16; j++) begin
            on = (j >= 2) && ((((j - 2) / 4) % 2) == 0);
            cyc(0, 1, (j == 5), (j == 7), (j == 9), 2'd2, on, 0, 1, {tag, "_fl"});
        end
        if (exp_lock) begin
            n = (stop_at > 0) ? stop_at : 20;
            for (int i = 1; i <= n; i++) begin
                cyc(0, 1, (i == 3), (i == 8), (i == 12), 2'd3, (i >= 2), 0, 1, {tag, "_lo"});
            end
            if (stop_at == 0) begin
                cyc(0, 1, 0, 0, 0, 2'd0, 1, 0, 0, {tag, "_lo_end"});
                cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, {tag, "_idle"});
            end
        end else begin
            cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, {tag, "_end"});
            cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, {tag, "_idle"});
        end
    endtask

    initial begin
        logic pat[7];
        logic prev;
        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset held: outputs cleared even with PWM active
        @(posedge clk); #1;
        pwm_12p5 = 1'b1; pwm_25 = 1'b1;
        push_exp(2'd0, 0, 0, 0, "in_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp(2'd0, 0, 0, 0, "rst_rel");
        @(posedge clk); #1;

        // LOCKED: led_r follows pwm_12p5 one cycle late, pwm_25 has no effect
        prev = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(pat[i], ~pat[i], 0, 0, 0, 2'd0, prev, 0, 0, "locked_dim");
            prev = pat[i];
        end

        unlock_relock("a");

        // Three consecutive failures; the third leads to lockout when enabled
        flash(0, 0, 0, "f1");
        flash(0, 0, 0, "f2");
        flash(0, LOCKOUT_ON, 0, "f3");
        unlock_relock("post_lo");

        // Simultaneous fail and unlock: fail wins, unlock during flash ignored
        flash(1, 0, 0, "co");

        // Two more failures reach lockout, then reset in the middle of it
        flash(0, 0, 0, "f5");
        flash(0, LOCKOUT_ON, 6, "f6");
        reset = 1'b1;
        unlock_pulse = 1'b0; fail_pulse = 1'b0; lock_pulse = 1'b0;
        push_exp(2'd0, 0, 0, 0, "rst_mid");
        @(posedge clk); #1;
        push_exp(2'd0, 0, 0, 0, "rst_hold");
        @(posedge clk); #1;
        reset = 1'b0;
        push_exp(2'd0, 0, 0, 0, "rst_rel2");
        @(posedge clk); #1;
        cyc(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, "post_rst");

        // Fail count was cleared by reset: a single failure returns to LOCKED
        flash(0, 0, 0, "f7");

        @(posedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
